pulse_scheduler: RTL

Shares one programmable pulse generator between `NREQ` requesters. Pending requests are arbitrated round-robin. The winner's per-channel configuration is latched, and one pulse of the configured delay and width is produced on a shared output. The winner then gets a one-cycle completion strobe. The block sits between the trigger sources and the pulse output stage, and replaces per-source fixed-width, fixed-delay pulse generators.

---
 rtl/pulse_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/pulse_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types, default channel configuration and helpers for the pulse scheduler.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_DELAY = 0;

    // Index of the set bit in a one-hot vector of up to 16 bits; 0 when empty.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and wraps.
module rr_arbiter
    import pulse_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] last_idx,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(last_idx) + k) % NREQ);
            if (!valid && eligible[cand]) begin
                valid            = 1'b1;
                win_onehot[cand] = 1'b1;
            end
        end
        win_idx = IDX_W'(onehot_to_idx(16'(win_onehot)));
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one programmable delay/width pulse generator among NREQ requesters,
// arbitrated round-robin, with a per-owner completion strobe.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH_W = 10,
    parameter  int DELAY_W = 4,
    parameter  int GAP     = 2,
    localparam int IDX_W   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               pulse_out,
    output logic               busy
);

    localparam int WD_MAX = (WIDTH_W > DELAY_W) ? WIDTH_W : DELAY_W;
    localparam int CNT_W  = (WD_MAX > 4) ? WD_MAX : 4;

    logic [WIDTH_W-1:0] width_tab [NREQ];
    logic [DELAY_W-1:0] delay_tab [NREQ];

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH_W-1:0] width_reg, width_next;
    logic [NREQ-1:0]    grant_reg, grant_next;
    logic [NREQ-1:0]    done_reg, done_next;
    logic               pulse_reg, pulse_next;
    logic               busy_reg, busy_next;
    logic [IDX_W-1:0]   last_reg, last_next;

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    // A zero width masks the channel from arbitration.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] && (width_tab[gi] != '0);
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .eligible   (eligible),
        .last_idx   (last_reg),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .valid      (win_valid)
    );

    // Out-of-range indices never match a channel, so they write nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                width_tab[i] <= WIDTH_W'(DEF_WIDTH);
                delay_tab[i] <= DELAY_W'(DEF_DELAY);
            end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                width_tab[i] <= cfg_width;
                delay_tab[i] <= cfg_delay;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        width_next = width_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        done_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_next = win_onehot;
                    last_next  = win_idx;
                    width_next = width_tab[win_idx];
                    if (delay_tab[win_idx] != '0) begin
                        state_next = ST_DELAY;
                        cnt_next   = CNT_W'(delay_tab[win_idx]);
                    end else begin
                        state_next = ST_PULSE;
                        cnt_next   = CNT_W'(width_tab[win_idx]);
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_PULSE;
                    cnt_next   = CNT_W'(width_reg);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_reg == CNT_W'(1)) begin
                    done_next  = grant_reg;
                    grant_next = '0;
                    if (GAP == 0) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = CNT_W'(GAP);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                grant_next = '0;
            end
        endcase
        // Outputs are registered copies of what the next state implies.
        pulse_next = (state_next == ST_PULSE);
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            width_reg <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            pulse_reg <= 1'b0;
            busy_reg  <= 1'b0;
            last_reg  <= IDX_W'(NREQ - 1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            width_reg <= width_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            pulse_reg <= pulse_next;
            busy_reg  <= busy_next;
            last_reg  <= last_next;
        end
    end

    assign grant     = grant_reg;
    assign done      = done_reg;
    assign pulse_out = pulse_reg;
    assign busy      = busy_reg;

endmodule
